osd_him_sf: RTL and testbench

// Host interface for Open SoC Debug: bridges a 16-bit GLIP byte-stream channel to the DII flit network.

---
 rtl/osd_him_sf.sv | 254 +++++++++++++++++++++++++
 tb/tb_osd_him_sf.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_him_sf.sv
// osd_him_sf: store-and-forward bridge between a 16-bit GLIP word stream and the DII flit network.
// Define OSD_HIM_STATS_EN to add the err_ingress_cnt/err_egress_cnt statistics ports.
module osd_him_sf #(
    parameter int unsigned MAX_PKT_LEN    = 12,
    parameter int unsigned LEN_W          = 5,
    parameter int unsigned IN_BUF_DEPTH   = 12,
    parameter int unsigned OUT_BUF_DEPTH  = 12,
    parameter int unsigned LEN_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] glip_in_data,
    input  logic        glip_in_valid,
    output logic        glip_in_ready,
    output logic [15:0] glip_out_data,
    output logic        glip_out_valid,
    input  logic        glip_out_ready,
    output logic [15:0] dii_out_data,
    output logic        dii_out_valid,
    output logic        dii_out_last,
    input  logic        dii_out_ready,
`ifdef OSD_HIM_STATS_EN
    output logic [15:0] err_ingress_cnt,
    output logic [15:0] err_egress_cnt,
`endif
    input  logic [15:0] dii_in_data,
    input  logic        dii_in_valid,
    input  logic        dii_in_last,
    output logic        dii_in_ready
);

    localparam int unsigned IPW = (IN_BUF_DEPTH > 1) ? $clog2(IN_BUF_DEPTH) : 1;
    localparam int unsigned ICW = $clog2(IN_BUF_DEPTH + 1);
    localparam int unsigned OPW = (OUT_BUF_DEPTH > 1) ? $clog2(OUT_BUF_DEPTH) : 1;
    localparam int unsigned OCW = $clog2(OUT_BUF_DEPTH + 1);
    localparam int unsigned LFW = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
    localparam int unsigned LCW = $clog2(LEN_FIFO_DEPTH + 1);

    localparam logic [IPW-1:0]   IN_PTR_LAST  = IPW'(IN_BUF_DEPTH - 1);
    localparam logic [OPW-1:0]   OUT_PTR_LAST = OPW'(OUT_BUF_DEPTH - 1);
    localparam logic [LFW-1:0]   LF_PTR_LAST  = LFW'(LEN_FIFO_DEPTH - 1);
    localparam logic [LEN_W-1:0] MAX_LEN      = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] ONE          = LEN_W'(1);

    // ------------------------------------------------------------------
    // Ingress: GLIP -> DII
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {ING_IDLE, ING_PAYLOAD, ING_DISCARD} ing_state_e;

    ing_state_e       ing_state_q;
    logic [LEN_W-1:0] ing_rem_q;
    logic [16:0]      ibuf_q [IN_BUF_DEPTH];
    logic [IPW-1:0]   iwr_ptr_q, ird_ptr_q;
    logic [ICW-1:0]   iocc_q, iocc_d;
    logic [ICW-1:0]   ipkt_q, ipkt_d;

    logic [LEN_W-1:0] hdr_len;
    logic [ICW-1:0]   ing_free;
    logic             hdr_zero, hdr_long, hdr_fits;
    logic             ing_fire, ibuf_wr, wr_last, ibuf_rd;

    assign hdr_len  = glip_in_data[LEN_W-1:0];
    assign hdr_zero = (hdr_len == '0);
    assign hdr_long = (hdr_len > MAX_LEN);
    assign ing_free = ICW'(IN_BUF_DEPTH) - iocc_q;
    assign hdr_fits = (32'(ing_free) >= 32'(hdr_len));

    // A legal header is held off until its whole payload is guaranteed room.
    assign glip_in_ready = !((ing_state_q == ING_IDLE) && glip_in_valid &&
                             !hdr_zero && !hdr_long && !hdr_fits);

    assign ing_fire = glip_in_valid && glip_in_ready;
    assign ibuf_wr  = ing_fire && (ing_state_q == ING_PAYLOAD);
    assign wr_last  = (ing_rem_q == ONE);

    assign dii_out_valid = (ipkt_q != '0);
    assign dii_out_data  = ibuf_q[ird_ptr_q][15:0];
    assign dii_out_last  = ibuf_q[ird_ptr_q][16];
    assign ibuf_rd       = dii_out_valid && dii_out_ready;

    always_comb begin
        iocc_d = iocc_q + ICW'(ibuf_wr) - ICW'(ibuf_rd);
        ipkt_d = ipkt_q + ICW'(ibuf_wr && wr_last) - ICW'(ibuf_rd && dii_out_last);
    end

    always_ff @(posedge clk) begin
        if (ibuf_wr) begin
            ibuf_q[iwr_ptr_q] <= {wr_last, glip_in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ing_state_q <= ING_IDLE;
            ing_rem_q   <= '0;
            iwr_ptr_q   <= '0;
            ird_ptr_q   <= '0;
            iocc_q      <= '0;
            ipkt_q      <= '0;
        end else begin
            iocc_q <= iocc_d;
            ipkt_q <= ipkt_d;
            if (ibuf_wr) begin
                iwr_ptr_q <= (iwr_ptr_q == IN_PTR_LAST) ? '0 : iwr_ptr_q + 1'b1;
            end
            if (ibuf_rd) begin
                ird_ptr_q <= (ird_ptr_q == IN_PTR_LAST) ? '0 : ird_ptr_q + 1'b1;
            end
            if (ing_fire) begin
                case (ing_state_q)
                    ING_IDLE: begin
                        if (!hdr_zero) begin
                            ing_rem_q   <= hdr_len;
                            ing_state_q <= hdr_long ? ING_DISCARD : ING_PAYLOAD;
                        end
                    end
                    ING_PAYLOAD, ING_DISCARD: begin
                        ing_rem_q <= ing_rem_q - ONE;
                        if (ing_rem_q == ONE) begin
                            ing_state_q <= ING_IDLE;
                        end
                    end
                    default: ing_state_q <= ING_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Egress: DII -> GLIP
    // ------------------------------------------------------------------
    typedef enum logic {EG_IDLE, EG_SEND} eg_state_e;

    eg_state_e        eg_state_q;
    logic [LEN_W-1:0] eg_rem_q;
    logic [15:0]      obuf_q [OUT_BUF_DEPTH];
    logic [OPW-1:0]   owr_ptr_q, ord_ptr_q;
    logic [OCW-1:0]   oocc_q, oocc_d;
    logic [LEN_W-1:0] lfifo_q [LEN_FIFO_DEPTH];
    logic [LFW-1:0]   lwr_ptr_q, lrd_ptr_q;
    logic [LCW-1:0]   locc_q, locc_d;
    logic [LEN_W-1:0] cnt_q, cnt_inc;
    logic             drop_q;

    logic obuf_full, lf_full, in_fire, obuf_wr, pkt_cap, lf_push, trunc;
    logic out_fire, obuf_rd, lf_pop;

    assign obuf_full    = (oocc_q == OCW'(OUT_BUF_DEPTH));
    assign lf_full      = (locc_q == LCW'(LEN_FIFO_DEPTH));
    assign dii_in_ready = drop_q || (!obuf_full && !lf_full);
    assign in_fire      = dii_in_valid && dii_in_ready;
    assign obuf_wr      = in_fire && !drop_q;
    assign cnt_inc      = cnt_q + ONE;
    assign pkt_cap      = (cnt_inc == MAX_LEN);
    assign lf_push      = obuf_wr && (dii_in_last || pkt_cap);
    assign trunc        = obuf_wr && pkt_cap && !dii_in_last;

    // Valid depends only on registered state, so host ready never loops back into it.
    assign glip_out_valid = (eg_state_q == EG_IDLE) ? (locc_q != '0) : (oocc_q != '0);
    assign glip_out_data  = (eg_state_q == EG_IDLE) ? 16'(lfifo_q[lrd_ptr_q]) : obuf_q[ord_ptr_q];
    assign out_fire       = glip_out_valid && glip_out_ready;
    assign obuf_rd        = out_fire && (eg_state_q == EG_SEND);
    assign lf_pop         = obuf_rd && (eg_rem_q == ONE);

    always_comb begin
        oocc_d = oocc_q + OCW'(obuf_wr) - OCW'(obuf_rd);
        locc_d = locc_q + LCW'(lf_push) - LCW'(lf_pop);
    end

    always_ff @(posedge clk) begin
        if (obuf_wr) begin
            obuf_q[owr_ptr_q] <= dii_in_data;
        end
        if (lf_push) begin
            lfifo_q[lwr_ptr_q] <= cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eg_state_q <= EG_IDLE;
            eg_rem_q   <= '0;
            owr_ptr_q  <= '0;
            ord_ptr_q  <= '0;
            oocc_q     <= '0;
            lwr_ptr_q  <= '0;
            lrd_ptr_q  <= '0;
            locc_q     <= '0;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            oocc_q <= oocc_d;
            locc_q <= locc_d;
            if (obuf_wr) begin
                owr_ptr_q <= (owr_ptr_q == OUT_PTR_LAST) ? '0 : owr_ptr_q + 1'b1;
                cnt_q     <= lf_push ? '0 : cnt_inc;
            end
            if (obuf_rd) begin
                ord_ptr_q <= (ord_ptr_q == OUT_PTR_LAST) ? '0 : ord_ptr_q + 1'b1;
            end
            if (lf_push) begin
                lwr_ptr_q <= (lwr_ptr_q == LF_PTR_LAST) ? '0 : lwr_ptr_q + 1'b1;
            end
            if (lf_pop) begin
                lrd_ptr_q <= (lrd_ptr_q == LF_PTR_LAST) ? '0 : lrd_ptr_q + 1'b1;
            end
            if (trunc) begin
                drop_q <= 1'b1;
            end else if (in_fire && drop_q && dii_in_last) begin
                drop_q <= 1'b0;
            end
            if (out_fire) begin
                case (eg_state_q)
                    EG_IDLE: begin
                        eg_rem_q   <= lfifo_q[lrd_ptr_q];
                        eg_state_q <= EG_SEND;
                    end
                    EG_SEND: begin
                        eg_rem_q <= eg_rem_q - ONE;
                        if (eg_rem_q == ONE) begin
                            eg_state_q <= EG_IDLE;
                        end
                    end
                    default: eg_state_q <= EG_IDLE;
                endcase
            end
        end
    end

`ifdef OSD_HIM_STATS_EN
    logic [15:0] ing_err_q, eg_err_q;
    logic        ing_err_ev;

    assign ing_err_ev = ing_fire && (ing_state_q == ING_IDLE) && (hdr_zero || hdr_long);

    always_ff @(posedge clk) begin
        if (rst) begin
            ing_err_q <= '0;
            eg_err_q  <= '0;
        end else begin
            if (ing_err_ev && (ing_err_q != '1)) begin
                ing_err_q <= ing_err_q + 16'd1;
            end
            if (trunc && (eg_err_q != '1)) begin
                eg_err_q <= eg_err_q + 16'd1;
            end
        end
    end

    assign err_ingress_cnt = ing_err_q;
    assign err_egress_cnt  = eg_err_q;
`endif

endmodule

// File: tb/tb_osd_him_sf.sv
// Directed bench for osd_him_sf: queue-based packet model, per-cycle output compare, literal spot checks.
module tb_osd_him_sf;
    localparam int MAX = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] glip_in_data, glip_out_data, dii_out_data, dii_in_data;
    logic        glip_in_valid, glip_in_ready, glip_out_valid, glip_out_ready;
    logic        dii_out_valid, dii_out_last, dii_out_ready;
    logic        dii_in_valid, dii_in_last, dii_in_ready;
`ifdef OSD_HIM_STATS_EN
    logic [15:0] err_ingress_cnt, err_egress_cnt;
`endif

    always #5 clk = ~clk;

    osd_him_sf #(
        .MAX_PKT_LEN(12), .LEN_W(5), .IN_BUF_DEPTH(12), .OUT_BUF_DEPTH(12), .LEN_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .glip_in_data(glip_in_data), .glip_in_valid(glip_in_valid), .glip_in_ready(glip_in_ready),
        .glip_out_data(glip_out_data), .glip_out_valid(glip_out_valid), .glip_out_ready(glip_out_ready),
        .dii_out_data(dii_out_data), .dii_out_valid(dii_out_valid), .dii_out_last(dii_out_last),
        .dii_out_ready(dii_out_ready),
`ifdef OSD_HIM_STATS_EN
        .err_ingress_cnt(err_ingress_cnt), .err_egress_cnt(err_egress_cnt),
`endif
        .dii_in_data(dii_in_data), .dii_in_valid(dii_in_valid), .dii_in_last(dii_in_last),
        .dii_in_ready(dii_in_ready)
    );

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    int exp_ing_err = 0;
    int exp_eg_err = 0;

    logic [16:0] exp_dii[$];
    logic [15:0] exp_glip[$];
    logic [16:0] dii_log[$];
    logic [15:0] glip_log[$];
    int unsigned glip_cyc[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Per-cycle compare of both output streams against the model queues.
    logic        pv = 1'b0, pr = 1'b0;
    logic [15:0] pd = '0;
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("glip_hold_valid", 32'(glip_out_valid), 32'd1);
                if (glip_out_valid) check("glip_hold_data", 32'(glip_out_data), 32'(pd));
            end
            if (dii_out_valid && dii_out_ready) begin
                dii_log.push_back({dii_out_last, dii_out_data});
                if (exp_dii.size() == 0) fail_now("dii_out_unexpected_flit");
                else check("dii_out", 32'({dii_out_last, dii_out_data}), 32'(exp_dii.pop_front()));
            end
            if (glip_out_valid && glip_out_ready) begin
                glip_log.push_back(glip_out_data);
                glip_cyc.push_back(cyc);
                if (exp_glip.size() == 0) fail_now("glip_out_unexpected_word");
                else check("glip_out", 32'(glip_out_data), 32'(exp_glip.pop_front()));
            end
            pv = glip_out_valid;
            pr = glip_out_ready;
            pd = glip_out_data;
        end
    end

    // Model: what a GLIP packet with this header must produce on DII.
    task automatic model_host(input logic [15:0] hdr, input logic [15:0] base);
        int len = int'(hdr[4:0]);
        if (len == 0 || len > MAX) exp_ing_err++;
        else for (int i = 0; i < len; i++) exp_dii.push_back({(i == len - 1), base + 16'(i)});
    endtask

    // Model: what an n-flit DII packet must produce on GLIP.
    task automatic model_dii(input int n, input logic [15:0] base);
        int l = (n > MAX) ? MAX : n;
        exp_glip.push_back(16'(l));
        for (int i = 0; i < l; i++) exp_glip.push_back(base + 16'(i));
        if (n > MAX) exp_eg_err++;
    endtask

    task automatic host_word(input logic [15:0] w);
        int n = 0;
        logic r;
        glip_in_valid = 1'b1;
        glip_in_data  = w;
        do begin
            @(negedge clk); r = glip_in_ready;
            @(posedge clk); #1; n++;
        end while (!r && n < 300);
        if (!r) fail_now("glip_in_ready_timeout");
        glip_in_valid = 1'b0;
    endtask

    task automatic host_pkt(input logic [15:0] hdr, input int nwords, input logic [15:0] base);
        model_host(hdr, base);
        host_word(hdr);
        for (int i = 0; i < nwords; i++) host_word(base + 16'(i));
    endtask

    task automatic dii_pkt(input int n, input logic [15:0] base);
        model_dii(n, base);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            logic r;
            dii_in_valid = 1'b1;
            dii_in_data  = base + 16'(i);
            dii_in_last  = (i == n - 1);
            do begin
                @(negedge clk); r = dii_in_ready;
                @(posedge clk); #1; k++;
            end while (!r && k < 300);
            if (!r) fail_now("dii_in_ready_timeout");
        end
        dii_in_valid = 1'b0;
        dii_in_last  = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_dii.size() != 0 || exp_glip.size() != 0) && k < 1000) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 1000) fail_now("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        glip_in_data = '0; glip_in_valid = 1'b0; glip_out_ready = 1'b0;
        dii_in_data = '0; dii_in_valid = 1'b0; dii_in_last = 1'b0; dii_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_glip_out_valid", 32'(glip_out_valid), 32'd0);
        check("rst_dii_out_valid", 32'(dii_out_valid), 32'd0);
        check("rst_glip_in_ready", 32'(glip_in_ready), 32'd1);
        check("rst_dii_in_ready", 32'(dii_in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Header 3 (upper bits set, ignored) + A,B,C; no valid until C is stored.
        model_host(16'h8003, 16'h00A0);
        host_word(16'h8003);
        host_word(16'h00A0);
        host_word(16'h00A1);
        @(negedge clk);
        check("t1_valid_before_last", 32'(dii_out_valid), 32'd0);
        @(posedge clk); #1;
        host_word(16'h00A2);
        @(negedge clk);
        check("t1_valid_after_last", 32'(dii_out_valid), 32'd1);
        check("t1_head_word", 32'({dii_out_last, dii_out_data}), 32'h000A0);
        @(posedge clk); #1;
        dii_out_ready = 1'b1;
        drain();

        // Header 0 then header 1 + D.
        dii_log.delete();
        host_pkt(16'h0000, 0, 16'h0000);
        host_pkt(16'h0001, 1, 16'h00D0);
        drain();
        check("t2_count", 32'(dii_log.size()), 32'd1);
        if (dii_log.size() > 0) check("t2_word", 32'(dii_log[0]), 32'h100D0);

        // Overlong header 13 with 13 words dropped, then header 2 + E,F.
        dii_log.delete();
        host_pkt(16'h000D, 13, 16'h0300);
        host_pkt(16'h0002, 2, 16'h00E0);
        drain();
        check("t3_count", 32'(dii_log.size()), 32'd2);
        if (dii_log.size() > 1) begin
            check("t3_word0", 32'(dii_log[0]), 32'h000E0);
            check("t3_word1", 32'(dii_log[1]), 32'h100E1);
        end

        // Full buffer (MAX-length packet) holds the next header off.
        dii_out_ready = 1'b0;
        host_pkt(16'h000C, 12, 16'h0100);
        glip_in_valid = 1'b1;
        glip_in_data  = 16'h0002;
        repeat (3) begin
            @(negedge clk);
            check("bp_header_held", 32'(glip_in_ready), 32'd0);
        end
        @(posedge clk); #1;
        dii_out_ready = 1'b1;
        host_pkt(16'h0002, 2, 16'h0200);
        drain();

        // Egress: 2-flit then 1-flit packet back to back.
        glip_out_ready = 1'b1;
        glip_log.delete();
        glip_cyc.delete();
        dii_pkt(2, 16'h0A00);
        dii_pkt(1, 16'h0B00);
        drain();
        check("t4_count", 32'(glip_log.size()), 32'd5);
        if (glip_log.size() == 5) begin
            check("t4_hdr0", 32'(glip_log[0]), 32'h0002);
            check("t4_x", 32'(glip_log[1]), 32'h0A00);
            check("t4_y", 32'(glip_log[2]), 32'h0A01);
            check("t4_hdr1", 32'(glip_log[3]), 32'h0001);
            check("t4_z", 32'(glip_log[4]), 32'h0B00);
            for (int i = 0; i < 4; i++) begin
                if (glip_cyc[i + 1] - glip_cyc[i] > 2) begin
                    total++; bad++;
                    $display("FAIL t4_bubble: gap %0d cycles after word %0d, required <= 2",
                             glip_cyc[i + 1] - glip_cyc[i], i);
                end else total++;
            end
        end

        // Egress: 14-flit packet truncated to 12, then a normal 1-flit packet.
        glip_log.delete();
        dii_pkt(14, 16'h0C00);
        dii_pkt(1, 16'h0D00);
        drain();
        check("t5_count", 32'(glip_log.size()), 32'd15);
        if (glip_log.size() == 15) begin
            check("t5_hdr", 32'(glip_log[0]), 32'h000C);
            check("t5_last_kept", 32'(glip_log[12]), 32'h0C0B);
            check("t5_next_hdr", 32'(glip_log[13]), 32'h0001);
        end

`ifdef OSD_HIM_STATS_EN
        check("stats_ingress_model", 32'(err_ingress_cnt), 32'(exp_ing_err));
        check("stats_egress_model", 32'(err_egress_cnt), 32'(exp_eg_err));
        check("stats_ingress_lit", 32'(err_ingress_cnt), 32'd2);
        check("stats_egress_lit", 32'(err_egress_cnt), 32'd1);
`endif

        // Stalled/toggling host ready, then reset in the middle of SEND.
        glip_out_ready = 1'b0;
        dii_pkt(6, 16'h0E00);
        for (int i = 0; i < 9; i++) begin
            glip_out_ready = ~glip_out_ready;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        exp_glip.delete();
        exp_dii.delete();
        exp_ing_err = 0;
        exp_eg_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        glip_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_glip_out_valid", 32'(glip_out_valid), 32'd0);
            check("post_rst_dii_out_valid", 32'(dii_out_valid), 32'd0);
        end
`ifdef OSD_HIM_STATS_EN
        check("post_rst_stats_ing", 32'(err_ingress_cnt), 32'd0);
        check("post_rst_stats_eg", 32'(err_egress_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        dii_pkt(1, 16'h0F00);
        host_pkt(16'h0001, 1, 16'h00F1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
